// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, ALU/load writeback ports, load scoreboard and status.
// master drives addresses/writes/sets; slave is the register file.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                w0_en;
    logic [AW-1:0]       w0_addr;
    logic [XLEN-1:0]     w0_data;
    logic                w1_en;
    logic [AW-1:0]       w1_addr;
    logic [XLEN-1:0]     w1_data;
    logic                sb_set_en;
    logic [AW-1:0]       sb_set_addr;
    logic [CW-1:0]       busy_cnt;
    logic                sb_err;
    logic                wcol;

    modport master (
        output rd_addr, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
               sb_set_en, sb_set_addr,
        input  rd_data, rd_busy, busy_cnt, sb_err, wcol
    );

    modport slave (
        input  rd_addr, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
               sb_set_en, sb_set_addr,
        output rd_data, rd_busy, busy_cnt, sb_err, wcol
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file: NRD bypassed read ports, ALU (W0) and load (W1) writeback,
// and a per-register load scoreboard with an incrementally maintained busy count.
module regfile_sb_rport #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic                       byp_en,
    input  logic [AW-1:0]              addr,
    input  logic [NREG-1:0][XLEN-1:0]  regs,
    input  logic [NREG-1:0]            busy,
    input  logic                       w0_en,
    input  logic [AW-1:0]              w0_addr,
    input  logic [XLEN-1:0]            w0_data,
    input  logic                       w1_en,
    input  logic [AW-1:0]              w1_addr,
    input  logic [XLEN-1:0]            w1_data,
    output logic [XLEN-1:0]            data,
    output logic                       busy_o
);
    logic w0_hit, w1_hit;

    assign w0_hit = byp_en && w0_en && (w0_addr == addr);
    assign w1_hit = byp_en && w1_en && (w1_addr == addr);

    // W0 has priority so the bypassed value equals what the edge will store.
    always_comb begin
        data   = regs[addr];
        busy_o = busy[addr] && !w1_hit;
        if (addr == '0) begin
            data   = '0;
            busy_o = 1'b0;
        end else if (w0_hit) begin
            data = w0_data;
        end else if (w1_hit) begin
            data = w1_data;
        end
    end
endmodule

module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           busy;
    logic [NREG-1:0]           set_vec, clr_vec, w0_vec;
    logic [CW-1:0]             busy_cnt_q;
    logic                      sb_err_q;
    logic                      inc, dec, err;
    logic [NRD-1:0][XLEN-1:0]  rd_data_v;
    logic [NRD-1:0]            rd_busy_v;

    // One-hot decode of each port's target; x0 is masked out everywhere.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        w0_vec  = '0;
        if (bus.sb_set_en) set_vec[bus.sb_set_addr] = 1'b1;
        if (bus.w1_en)     clr_vec[bus.w1_addr]     = 1'b1;
        if (bus.w0_en)     w0_vec[bus.w0_addr]      = 1'b1;
        set_vec[0] = 1'b0;
        clr_vec[0] = 1'b0;
        w0_vec[0]  = 1'b0;
    end

    assign inc = |(set_vec & ~busy);
    assign dec = |(clr_vec & busy & ~set_vec);
    assign err = (|(set_vec & busy & ~clr_vec))
               | (|(clr_vec & ~busy))
               | (|(w0_vec & busy & ~clr_vec));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs       <= '0;
            busy       <= '0;
            busy_cnt_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w0_vec[r])       regs[r] <= bus.w0_data;
                else if (clr_vec[r]) regs[r] <= bus.w1_data;
            end
            // Set wins over clear: a fresh load re-targeted the same destination.
            busy       <= set_vec | (busy & ~clr_vec);
            busy_cnt_q <= busy_cnt_q + CW'(inc) - CW'(dec);
            sb_err_q   <= err;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_sb_rport #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rport (
            .byp_en  (rst_n),
            .addr    (bus.rd_addr[k*AW +: AW]),
            .regs    (regs),
            .busy    (busy),
            .w0_en   (bus.w0_en),
            .w0_addr (bus.w0_addr),
            .w0_data (bus.w0_data),
            .w1_en   (bus.w1_en),
            .w1_addr (bus.w1_addr),
            .w1_data (bus.w1_data),
            .data    (rd_data_v[k]),
            .busy_o  (rd_busy_v[k])
        );
    end

    assign bus.rd_data  = rd_data_v;
    assign bus.rd_busy  = rd_busy_v;
    assign bus.busy_cnt = busy_cnt_q;
    assign bus.sb_err   = sb_err_q;
    assign bus.wcol     = bus.w0_en && bus.w1_en && (bus.w0_addr == bus.w1_addr)
                          && (bus.w0_addr != '0);
endmodule

// File: tb/tb_regfile_sb.sv
// Randomized + directed bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [XLEN-1:0] m_reg [NREG];
    bit              m_busy [NREG];
    bit              m_err = 1'b0;

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] raddr(input int k);
        logic [NRD*AW-1:0] v;
        v = bus.rd_addr;
        return v[k*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] rdata(input int k);
        logic [NRD*XLEN-1:0] v;
        v = bus.rd_data;
        return v[k*XLEN +: XLEN];
    endfunction

    // Model update on each rising edge; inputs change only 1ns after the edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            bit e;
            e = 1'b0;
            if (bus.sb_set_en && bus.sb_set_addr != 0 && m_busy[bus.sb_set_addr]
                && !(bus.w1_en && bus.w1_addr == bus.sb_set_addr)) e = 1'b1;
            if (bus.w1_en && bus.w1_addr != 0 && !m_busy[bus.w1_addr]) e = 1'b1;
            if (bus.w0_en && bus.w0_addr != 0 && m_busy[bus.w0_addr]
                && !(bus.w1_en && bus.w1_addr == bus.w0_addr)) e = 1'b1;
            if (bus.w1_en) m_reg[bus.w1_addr] = bus.w1_data;
            if (bus.w0_en) m_reg[bus.w0_addr] = bus.w0_data;
            if (bus.w1_en) m_busy[bus.w1_addr] = 1'b0;
            if (bus.sb_set_en) m_busy[bus.sb_set_addr] = 1'b1;
            m_reg[0]  = '0;
            m_busy[0] = 1'b0;
            m_err = e;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < NREG; i++) cnt += int'(m_busy[i]);
            for (int k = 0; k < NRD; k++) begin
                logic [AW-1:0]   a;
                logic [XLEN-1:0] ed;
                bit              eb;
                a = raddr(k);
                if (a == 0)                                          ed = '0;
                else if (rst_n && bus.w0_en && bus.w0_addr == a)     ed = bus.w0_data;
                else if (rst_n && bus.w1_en && bus.w1_addr == a)     ed = bus.w1_data;
                else                                                 ed = m_reg[a];
                eb = (a != 0) && m_busy[a] && !(rst_n && bus.w1_en && bus.w1_addr == a);
                chk($sformatf("rd_data[%0d]", k), 64'(rdata(k)), 64'(ed));
                chk($sformatf("rd_busy[%0d]", k), 64'(bus.rd_busy[k]), 64'(eb));
            end
            chk("wcol", 64'(bus.wcol), 64'(bus.w0_en && bus.w1_en
                && bus.w0_addr == bus.w1_addr && bus.w0_addr != 0));
            chk("busy_cnt", 64'(bus.busy_cnt), 64'(cnt));
            chk("sb_err", 64'(bus.sb_err), 64'(m_err));
        end
    end

    task automatic idle();
        bus.w0_en = 0; bus.w0_addr = '0; bus.w0_data = '0;
        bus.w1_en = 0; bus.w1_addr = '0; bus.w1_data = '0;
        bus.sb_set_en = 0; bus.sb_set_addr = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        logic [NRD*AW-1:0] v;
        v[0 +: AW]  = AW'(a0);
        v[AW +: AW] = AW'(a1);
        bus.rd_addr = v;
    endtask

    initial begin
        idle();
        set_rd(0, 0);
        rst_n = 0;
        cyc();
        chk_en = 1;
        // Reset state: every address reads 0 and not busy
        for (int a = 0; a < NREG; a++) begin
            set_rd(a, NREG - 1 - a);
            #1;
            chk("reset rd0", 64'(rdata(0)), 64'h0);
            chk("reset rd1", 64'(rdata(1)), 64'h0);
            chk("reset busy", 64'(bus.rd_busy), 64'h0);
            cyc();
        end
        chk("reset busy_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("reset sb_err", 64'(bus.sb_err), 64'd0);
        rst_n = 1;

        // W0 bypass and persistence; x0 write ignored
        cyc();
        bus.w0_en = 1; bus.w0_addr = 5; bus.w0_data = 32'hDEADBEEF;
        set_rd(5, 0);
        #1 chk("x5 bypass", 64'(rdata(0)), 64'hDEADBEEF);
        cyc();
        bus.w0_addr = 0; bus.w0_data = 32'h1234;
        #1 chk("x5 stored", 64'(rdata(0)), 64'hDEADBEEF);
        chk("x0 bypass", 64'(rdata(1)), 64'h0);
        cyc(); idle();
        #1 chk("x0 stored", 64'(rdata(1)), 64'h0);

        // Write collision: W0 wins
        cyc();
        bus.w0_en = 1; bus.w0_addr = 7; bus.w0_data = 32'h11;
        bus.w1_en = 1; bus.w1_addr = 7; bus.w1_data = 32'h22;
        set_rd(7, 0);
        #1 chk("wcol", 64'(bus.wcol), 64'd1);
        chk("x7 bypass", 64'(rdata(0)), 64'h11);
        cyc(); idle();
        #1 chk("x7 stored", 64'(rdata(0)), 64'h11);

        // Set x3, then load-writeback clears it with bypass
        cyc();
        bus.sb_set_en = 1; bus.sb_set_addr = 3;
        set_rd(3, 0);
        #1 chk("x3 set invisible", 64'(bus.rd_busy[0]), 64'd0);
        cyc(); idle();
        #1 chk("x3 busy", 64'(bus.rd_busy[0]), 64'd1);
        chk("cnt after x3", 64'(bus.busy_cnt), 64'd1);
        cyc();
        bus.w1_en = 1; bus.w1_addr = 3; bus.w1_data = 32'h55;
        #1 chk("x3 clr bypass", 64'(bus.rd_busy[0]), 64'd0);
        chk("x3 w1 bypass", 64'(rdata(0)), 64'h55);
        cyc(); idle();
        #1 chk("cnt after clr", 64'(bus.busy_cnt), 64'd0);
        chk("no err after clr", 64'(bus.sb_err), 64'd0);

        // Set+clear same cycle keeps x4 busy; re-set errors
        cyc(); bus.sb_set_en = 1; bus.sb_set_addr = 4; set_rd(4, 0);
        cyc(); idle();
        cyc();
        bus.sb_set_en = 1; bus.sb_set_addr = 4;
        bus.w1_en = 1; bus.w1_addr = 4; bus.w1_data = 32'h66;
        cyc(); idle();
        #1 chk("x4 still busy", 64'(bus.rd_busy[0]), 64'd1);
        chk("x4 cnt", 64'(bus.busy_cnt), 64'd1);
        chk("x4 no err", 64'(bus.sb_err), 64'd0);
        bus.sb_set_en = 1; bus.sb_set_addr = 4;
        cyc(); idle();
        #1 chk("x4 reset err", 64'(bus.sb_err), 64'd1);
        chk("x4 cnt same", 64'(bus.busy_cnt), 64'd1);
        cyc();
        #1 chk("err one cycle", 64'(bus.sb_err), 64'd0);

        // Fill the scoreboard, then reset mid-sequence
        for (int r = 1; r < NREG; r++) begin
            bus.sb_set_en = 1; bus.sb_set_addr = AW'(r);
            cyc();
        end
        idle();
        cyc();
        chk("cnt full", 64'(bus.busy_cnt), 64'd31);
        rst_n = 0;
        cyc();
        rst_n = 1;
        #1 chk("cnt after rst", 64'(bus.busy_cnt), 64'd0);
        for (int a = 0; a < NREG; a++) begin
            set_rd(a, a);
            #1 chk("rd after rst", 64'(rdata(0)), 64'h0);
            cyc();
        end

        // Randomized traffic on a narrow address window to force collisions
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            bus.w0_en = $urandom_range(0, 1);
            bus.w0_addr = AW'($urandom_range(0, 7));
            bus.w0_data = $urandom;
            bus.w1_en = ($urandom_range(0, 2) == 0);
            bus.w1_addr = AW'($urandom_range(0, 7));
            bus.w1_data = $urandom;
            bus.sb_set_en = ($urandom_range(0, 2) == 0);
            bus.sb_set_addr = AW'($urandom_range(0, 7));
            set_rd($urandom_range(0, 8), $urandom_range(0, 8));
            cyc();
        end
        rst_n = 1;
        idle();
        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
